// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the parametrised FIFO buffer.
package fifo_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 8;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage for the FIFO: one synchronous write port and one
// registered read port. Contents are deliberately not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = fifo_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Read port holds its last word when not enabled.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, level flags and
// sticky overflow/underflow around one fifo_ram instance.
module fifo_buffer_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int ADDR_W   = fifo_ptr_w(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w,
    input  logic              r,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_seen_q, rd_seen_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // A read frees a slot in the same edge, so a full FIFO still takes w&r.
    assign wr_acc = w & (~full | r);
    assign rd_acc = r & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_acc;
        rd_seen_d   = rd_seen_q | rd_acc;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end

        // A fresh error outranks a clear in the same cycle.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (r && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_seen_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_seen_q   <= rd_seen_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // The unreset read register is masked to zero until the first read
    // after reset, giving data_out a defined reset value.
    assign data_out  = rd_seen_q ? ram_rdata : '0;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Bench for fifo_buffer_param: directed and random traffic against a
// queue-based reference model.
module tb_fifo_buffer_param;

    localparam int DW = 16;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w = 1'b0;
    logic          r = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    fifo_buffer_param #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w            (w),
        .r            (r),
        .err_clr      (err_clr),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_rdv  = 1'b0;
    bit            m_ovf  = 1'b0;
    bit            m_udf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_rdv  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int sz;
        sz = mq.size();
        chk({ctx, ".count"},        32'(count),        32'(sz));
        chk({ctx, ".full"},         32'(full),         32'(sz == DP));
        chk({ctx, ".empty"},        32'(empty),        32'(sz == 0));
        chk({ctx, ".almost_full"},  32'(almost_full),  32'(sz >= 6));
        chk({ctx, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 2));
        chk({ctx, ".data_out"},     32'(data_out),     32'(m_dout));
        chk({ctx, ".rd_valid"},     32'(rd_valid),     32'(m_rdv));
        chk({ctx, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({ctx, ".underflow"},    32'(underflow),    32'(m_udf));
    endtask

    // One clock of traffic: drive on the falling edge, update the model at the
    // rising edge, check just after it.
    task automatic step(input bit wi, input bit ri, input logic [DW-1:0] d,
                        input bit ci, input string ctx);
        int sz;
        bit wok, rok;
        @(negedge clk);
        w = wi; r = ri; data_in = d; err_clr = ci;
        @(posedge clk);
        sz  = mq.size();
        wok = wi && (sz < DP || ri);
        rok = ri && (sz > 0);
        if (rok) m_dout = mq.pop_front();
        m_rdv = rok;
        if (wok) mq.push_back(d);
        m_ovf = (wi && !wok) ? 1'b1 : (ci ? 1'b0 : m_ovf);
        m_udf = (ri && !rok) ? 1'b1 : (ci ? 1'b0 : m_udf);
        #1;
        check_all(ctx);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset");

        for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0, "fill");
        step(1, 0, 16'hDEAD, 0, "overflow");
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, "drain");
        step(0, 1, '0, 0, "underflow");
        step(0, 0, '0, 1, "err_clr");

        for (int i = 0; i < 8; i++) step(1, 0, DW'(16'h0010 + i), 0, "refill");
        step(1, 1, 16'hC005, 0, "rw_full");
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, "drain2");
        step(1, 1, 16'h0077, 0, "rw_empty");
        step(0, 1, '0, 1, "rw_empty_read");

        for (int i = 0; i < 20; i++) begin
            step(1, 0, DW'(2 * i), 0, "wrap_w");
            step(0, 1, '0, 0, "wrap_r");
        end

        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 DW'($urandom), ($urandom_range(0, 15) == 0), "random");
        end

        for (int i = 0; i < 9; i++) step(0, 1, '0, 1, "pre_rst_drain");
        for (int i = 0; i < 5; i++) step(1, 0, DW'(16'h0050 + i), 0, "pre_rst_fill");
        chk("pre_rst_count", 32'(count), 32'd5);
        w = 1'b0; r = 1'b0; err_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 16'h00AA, 0, "post_rst_w");
        step(0, 1, '0, 0, "post_rst_r");
        chk("post_rst_data", 32'(data_out), 32'h00AA);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_buffer_param.md
Name: fifo_buffer_param

Overview:
- Parametrised synchronous FIFO buffer. Next generation of the single-word read/write memory buffer.
- Adds configurable width and depth, ordered multi-entry storage, and full/empty/almost flags.
- Adds an occupancy count and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in one clock domain.

Parameters:
- DATA_W, 16: data word width in bits.
- DEPTH, 8: number of entries. Must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH): pointer width. Derived; never overridden.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- w  input  1  write request.
- r  input  1  read request.
- err_clr  input  1  synchronous clear of overflow and underflow.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  data_out holds a freshly read word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Storage contents are not reset.
- Reset values of flags: full=0, empty=1, almost_empty=1, almost_full=0 (AF_LEVEL>0).
- Reset mid-operation discards all queued data immediately. The first edge after release sees an empty FIFO.
- Write acceptance: wr_acc = w & (~full | r).
  - When wr_acc, data_in is stored at wr_ptr and wr_ptr increments, wrapping DEPTH-1 -> 0 by natural ADDR_W rollover.
- Read acceptance: rd_acc = r & ~empty.
  - When rd_acc, data_out <= mem[rd_ptr] on that edge (latency 1), rd_ptr increments with wrap, and rd_valid=1 for the following cycle.
  - When no read is accepted, rd_valid=0 and data_out holds its last value.
- Simultaneous r & w:
  - Non-empty (including full): both accepted, count unchanged.
  - Empty: write accepted, read rejected (underflow sets). No write-through bypass; the word is readable from the next cycle.
- Count update: +1 on wr_acc only, -1 on rd_acc only, otherwise unchanged. Never leaves 0..DEPTH.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count. They are glitch-free relative to clk.
- overflow sets when w & ~wr_acc. underflow sets when r & ~rd_acc.
  - Both are held until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the set wins.
- A rejected request changes no pointer, count or data_out.
- Storage is inferred as a register array with one write port and one read port.

Decomposition:
- Package fifo_pkg:
  - default constants FIFO_DATA_W=16 and FIFO_DEPTH=8
  - a clog2-based helper for pointer width
- Sub-module fifo_ram (DATA_W, DEPTH):
  - synchronous-write, synchronous-read dual-port array
  - ports: clk, we, waddr, wdata, re, raddr, rdata
- fifo_buffer_param holds the pointers, count, flags and error logic, and instantiates one fifo_ram.

Test Plan (DATA_W=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset check: rst=1 for 2 cycles, then 0 -> count=0, empty=1, almost_empty=1, full=0, data_out=16'h0000, rd_valid=0, overflow=0, underflow=0.
- Fill then drain:
  - Write 16'h0001..16'h0008 on consecutive cycles -> full=1 and count=8 after the 8th edge; almost_full first seen at count=6; almost_empty cleared at count=3.
  - Read 8 times -> data_out returns 16'h0001..16'h0008 in order, each with rd_valid=1 one cycle after r; empty=1 at the end.
- Overflow/underflow:
  - With full=1, w=1 r=0, data_in=16'hDEAD -> overflow=1, count stays 8, 16'hDEAD never read back.
  - With empty=1, r=1 -> underflow=1, data_out unchanged, rd_valid=0.
  - err_clr=1 for one cycle -> both flags 0.
- Simultaneous r & w:
  - At count=8: w=r=1, data_in=16'hC005 -> count stays 8, no overflow; 16'hC005 emerges after the 7 older words.
  - At count=0: w=r=1 -> count=1, underflow=1.
- Pointer wrap: run 20 interleaved write/read pairs with data_in = cycle index -> outputs match a reference queue exactly; count never exceeds 1 (non-empty case).
- Reset mid-operation: at count=5, assert rst between clock edges -> count=0 and empty=1 immediately, without waiting for an edge; after release, a write of 16'h00AA then a read returns 16'h00AA.
